// File: rtl/volt_to_dac_code.sv
// volt_to_dac_code: sign-magnitude millivolt word -> 12-bit DAC code.
// Scales by 4096/FULL_MV with rounding using a restoring divider that
// produces one quotient bit per clock, then clamps to the 12-bit range.
module volt_to_dac_code #(
    parameter int FULL_MV  = 5000,
    parameter int ROUND_MV = 2500
) (
    input  logic        da_clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] out_code,
    output logic [11:0] out_offset,
    output logic        out_sat,
    output logic        out_valid,
    input  logic        out_ready
);
    typedef enum logic [1:0] {IDLE, DIV, SAT, OUT} state_t;

    state_t      state;
    logic        sign_q;
    logic [12:0] rem_q;
    logic [14:0] shf_q;
    logic [14:0] quo_q;
    logic [3:0]  cnt_q;

    logic [26:0] num;
    logic [13:0] r_ext;
    logic [13:0] r_diff;
    logic        ge;
    logic [12:0] r_nxt;
    logic [11:0] code_nxt;
    logic        sat_nxt;

    // Numerator mag*4096 + bias; the top 12 bits are always below FULL_MV,
    // so they can seed the remainder and only 15 quotient bits remain.
    assign num = {in_data[14:0], 12'd0} + 27'(ROUND_MV);

    // One restoring-division step: shift in the next numerator bit, subtract if it fits.
    assign r_ext  = {rem_q, shf_q[14]};
    assign r_diff = r_ext - 14'(FULL_MV);
    assign ge     = (r_ext >= 14'(FULL_MV));
    assign r_nxt  = ge ? r_diff[12:0] : r_ext[12:0];

    // Clamp the quotient into the signed 12-bit code range; -0 maps to plain 0.
    always_comb begin
        code_nxt = '0;
        sat_nxt  = 1'b0;
        if (!sign_q) begin
            if (quo_q > 15'd2047) begin
                code_nxt = 12'h7FF;
                sat_nxt  = 1'b1;
            end else begin
                code_nxt = quo_q[11:0];
            end
        end else begin
            if (quo_q > 15'd2048) begin
                code_nxt = 12'h800;
                sat_nxt  = 1'b1;
            end else begin
                code_nxt = 12'd0 - quo_q[11:0];
            end
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge da_clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_code   <= '0;
            out_offset <= 12'h800;
            out_sat    <= 1'b0;
            sign_q     <= 1'b0;
            rem_q      <= '0;
            shf_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone is an accept
                    if (in_valid) begin
                        sign_q   <= in_data[15];
                        rem_q    <= {1'b0, num[26:15]};
                        shf_q    <= num[14:0];
                        quo_q    <= '0;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                        state    <= DIV;
                    end
                end
                DIV: begin
                    rem_q <= r_nxt;
                    shf_q <= {shf_q[13:0], 1'b0};
                    quo_q <= {quo_q[13:0], ge};
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd14)
                        state <= SAT;
                end
                SAT: begin
                    out_code   <= code_nxt;
                    out_offset <= code_nxt ^ 12'h800;
                    out_sat    <= sat_nxt;
                    out_valid  <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_volt_to_dac_code.sv
// Bench for volt_to_dac_code: directed corner cases plus randomized traffic
// against a latency/queue-level reference model checked every cycle.
module tb_volt_to_dac_code;
    logic        da_clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] out_code;
    logic [11:0] out_offset;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    volt_to_dac_code dut (
        .da_clk    (da_clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_code  (out_code),
        .out_offset(out_offset),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 da_clk = ~da_clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference conversion straight from the arithmetic definition.
    function automatic void ref_conv(input logic [15:0] w, output logic [11:0] code,
                                     output logic sat);
        longint q;
        q = (longint'(w[14:0]) * 4096 + 2500) / 5000;
        sat = 1'b0;
        if (!w[15]) begin
            if (q > 2047) begin code = 12'h7FF; sat = 1'b1; end
            else code = 12'(q);
        end else begin
            if (q > 2048) begin code = 12'h800; sat = 1'b1; end
            else code = 12'(4096 - q);
        end
    endfunction

    // Cycle model: accept starts a 16-clock countdown, then the result is held
    // until the output handshake; reset wins over everything.
    bit          mon_en = 1'b0;
    bit          m_ready = 1'b1, m_valid = 1'b0, m_sat = 1'b0, p_sat;
    logic [11:0] m_code = '0, m_off = 12'h800, p_code;
    int          m_cd = 0;
    int          accepts = 0;

    always @(negedge da_clk) begin
        if (mon_en) begin
            chk("mon_in_ready", in_ready, m_ready);
            chk("mon_out_valid", out_valid, m_valid);
            chk("mon_out_code", out_code, m_code);
            chk("mon_out_offset", out_offset, m_off);
            chk("mon_out_sat", out_sat, m_sat);
            if (rst) begin
                m_ready = 1'b1; m_valid = 1'b0; m_cd = 0;
                m_code = '0; m_off = 12'h800; m_sat = 1'b0;
            end else if (m_ready && in_valid) begin
                m_ready = 1'b0; m_cd = 16;
                ref_conv(in_data, p_code, p_sat);
                accepts++;
            end else if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) begin
                    m_valid = 1'b1; m_code = p_code; m_off = p_code ^ 12'h800; m_sat = p_sat;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0; m_ready = 1'b1;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin @(posedge da_clk); #1; n++; end
        chk("wait_in_ready", in_ready, 1);
    endtask

    // Send one word with out_ready high; check latency and literal result.
    task automatic send(input logic [15:0] w, input logic [11:0] ec, input logic es,
                        input string nm);
        int n = 0;
        wait_ready();
        in_data = w; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge da_clk); #1;
        in_valid = 1'b0;
        while (!out_valid && n < 40) begin @(posedge da_clk); #1; n++; end
        chk({nm, "_latency"}, n, 16);
        chk({nm, "_code"}, out_code, ec);
        chk({nm, "_offset"}, out_offset, ec ^ 12'h800);
        chk({nm, "_sat"}, out_sat, es);
        @(posedge da_clk); #1;
        chk({nm, "_drop"}, out_valid, 0);
    endtask

    function automatic logic [15:0] pick();
        logic [14:0] m;
        case ($urandom_range(0, 7))
            0: m = 15'd0;
            1: m = 15'd1;
            2: m = 15'(2498 + $urandom_range(0, 3));
            3: m = 15'd32767;
            4, 5: m = 15'($urandom_range(0, 3000));
            default: m = 15'($urandom);
        endcase
        return {1'($urandom), m};
    endfunction

    initial begin
        logic [11:0] c, held;
        logic        s;
        int          n, target;

        // Pin the model on hand-computed values.
        ref_conv(16'h03E8, c, s); chk("ref_p1000", {s, c}, 13'h0333);
        ref_conv(16'h83E8, c, s); chk("ref_m1000", {s, c}, 13'h0CCD);
        ref_conv(16'h09C4, c, s); chk("ref_p2500", {s, c}, 13'h17FF);
        ref_conv(16'h89C4, c, s); chk("ref_m2500", {s, c}, 13'h0800);
        ref_conv(16'hFFFF, c, s); chk("ref_mmax", {s, c}, 13'h1800);
        ref_conv(16'h8000, c, s); chk("ref_negzero", {s, c}, 13'h0000);

        repeat (3) @(posedge da_clk);
        #1 mon_en = 1'b1;
        @(posedge da_clk); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_offset", out_offset, 12'h800);
        rst = 1'b0;

        send(16'h03E8, 12'h333, 1'b0, "p1000");
        send(16'h83E8, 12'hCCD, 1'b0, "m1000");
        send(16'h0000, 12'h000, 1'b0, "zero");
        send(16'h8000, 12'h000, 1'b0, "negzero");
        send(16'h0001, 12'h001, 1'b0, "p1");
        send(16'h09C3, 12'h7FF, 1'b0, "p2499");
        send(16'h09C4, 12'h7FF, 1'b1, "p2500");
        send(16'h89C4, 12'h800, 1'b0, "m2500");
        send(16'hFFFF, 12'h800, 1'b1, "mmax");

        // Backpressure: result held for 20 clocks, stray in_valid ignored.
        wait_ready();
        out_ready = 1'b0; in_data = 16'h03E8; in_valid = 1'b1;
        @(posedge da_clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(posedge da_clk); #1; n++; end
        chk("bp_latency", n, 16);
        held = out_code;
        chk("bp_code", held, 12'h333);
        for (int i = 0; i < 20; i++) begin
            in_valid = (i == 5);
            in_data  = 16'h0001;
            @(posedge da_clk); #1;
            chk("bp_hold_code", out_code, held);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge da_clk); #1;
        out_ready = 1'b0;
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        repeat (20) @(posedge da_clk);
        #1 chk("bp_no_stray", out_valid, 0);

        // Reset in the middle of a division.
        wait_ready();
        in_data = 16'h03E8; in_valid = 1'b1;
        @(posedge da_clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge da_clk);
        #1 rst = 1'b1;
        @(posedge da_clk); #1;
        rst = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 1);
        send(16'h03E8, 12'h333, 1'b0, "after_rst");

        // Random traffic with stalls and occasional resets.
        target = accepts + 1500;
        for (int cyc = 0; cyc < 60000 && accepts < target; cyc++) begin
            @(posedge da_clk); #1;
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = pick();
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 999) == 0);
        end
        @(posedge da_clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("rand_accept_count", (accepts >= target) ? 1 : 0, 1);
        repeat (25) @(posedge da_clk);
        #1 mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
